// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: captures a one-cycle request, holds it for
// WAIT_STATES extra cycles, commits the read/write and pulses done.
module dmem_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                cap_we;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                capture_c;
  logic                commit_c;
  logic                in_range_c;
  logic [IDX_W-1:0]    idx_c;

  // Compare at 32 bits so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range_c = (32'(cap_addr) < DEPTH);
  assign idx_c      = IDX_W'(cap_addr);

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          capture_c = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_STATES);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          commit_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any pending commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= commit_c;
      err   <= commit_c && !in_range_c;
      if (commit_c && !cap_we) begin
        rdata <= in_range_c ? mem[idx_c] : '0;
      end
    end
  end

  // Request capture; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (capture_c) begin
      cap_we    <= we;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

  // Storage array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && commit_c && cap_we && in_range_c) begin
      mem[idx_c] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl across four wait-state/depth configurations.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_v;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  err_v;
  logic [15:0] rdata_v [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(8), .DEPTH(200), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .rdata(rdata_v[0]));

  dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .rdata(rdata_v[1]));

  dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .rdata(rdata_v[2]));

  dmem_ctrl #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req(req_v[3]), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy_v[3]), .done(done_v[3]), .err(err_v[3]), .rdata(rdata_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on instance k; req is high in cycle 0, done expected in cycle exp_lat.
  task automatic access(input int k, input logic w, input logic [7:0] a,
                        input logic [15:0] d, input int exp_lat, input logic exp_err);
    int cyc;
    @(negedge clk);
    req_v[k] = 1'b1;
    we       = w;
    addr     = a;
    wdata    = d;
    @(negedge clk);
    req_v[k] = 1'b0;
    cyc      = 1;
    check($sformatf("busy_c1_u%0d_%0h", k, a), 32'(busy_v[k]), 32'd1);
    while (!done_v[k] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency_u%0d_%0h", k, a), 32'(cyc), 32'(exp_lat));
    check($sformatf("busy_done_u%0d_%0h", k, a), 32'(busy_v[k]), 32'd1);
    check($sformatf("err_u%0d_%0h", k, a), 32'(err_v[k]), 32'(exp_err));
    @(negedge clk);
    check($sformatf("done_width_u%0d_%0h", k, a), 32'(done_v[k]), 32'd0);
    check($sformatf("busy_idle_u%0d_%0h", k, a), 32'(busy_v[k]), 32'd0);
    check($sformatf("err_width_u%0d_%0h", k, a), 32'(err_v[k]), 32'd0);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    req_v = '0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_busy_u%0d", k), 32'(busy_v[k]), 32'd0);
      check($sformatf("rst_done_u%0d", k), 32'(done_v[k]), 32'd0);
      check($sformatf("rst_err_u%0d", k), 32'(err_v[k]), 32'd0);
      check($sformatf("rst_rdata_u%0d", k), 32'(rdata_v[k]), 32'h0);
    end
    rst = 1'b0;

    // Write then read, one wait state.
    access(0, 1'b1, 8'h10, 16'hA5C3, 3, 1'b0);
    access(0, 1'b0, 8'h10, 16'h0000, 3, 1'b0);
    check("rd_10", 32'(rdata_v[0]), 32'hA5C3);

    // Wait-state sweep.
    access(1, 1'b1, 8'h40, 16'h1234, 2, 1'b0);
    access(1, 1'b0, 8'h40, 16'h0000, 2, 1'b0);
    check("rd_ws0", 32'(rdata_v[1]), 32'h1234);
    access(2, 1'b1, 8'h40, 16'h4321, 7, 1'b0);
    access(2, 1'b0, 8'h40, 16'h0000, 7, 1'b0);
    check("rd_ws5", 32'(rdata_v[2]), 32'h4321);

    // Second request while busy is dropped.
    access(0, 1'b1, 8'h21, 16'h5A5A, 3, 1'b0);
    @(negedge clk);
    req_v[0] = 1'b1; we = 1'b1; addr = 8'h20; wdata = 16'h1111;
    @(negedge clk);
    addr = 8'h21; wdata = 16'h2222;
    @(negedge clk);
    req_v[0] = 1'b0;
    ndone = 0;
    repeat (8) begin
      if (done_v[0]) ndone++;
      @(negedge clk);
    end
    check("busy_req_one_done", 32'(ndone), 32'd1);
    access(0, 1'b0, 8'h20, 16'h0000, 3, 1'b0);
    check("rd_20", 32'(rdata_v[0]), 32'h1111);
    access(0, 1'b0, 8'h21, 16'h0000, 3, 1'b0);
    check("rd_21_unchanged", 32'(rdata_v[0]), 32'h5A5A);

    // Out-of-range accesses with DEPTH=200.
    access(0, 1'b0, 8'hC8, 16'h0000, 3, 1'b1);
    check("rd_oor_zero", 32'(rdata_v[0]), 32'h0);
    access(0, 1'b1, 8'hFF, 16'hDEAD, 3, 1'b1);
    check("wr_oor_rdata_hold", 32'(rdata_v[0]), 32'h0);
    access(0, 1'b0, 8'h10, 16'h0000, 3, 1'b0);
    check("rd_10_after_oor", 32'(rdata_v[0]), 32'hA5C3);

    // rdata holds across writes, even to the same address.
    access(0, 1'b1, 8'h05, 16'hBEEF, 3, 1'b0);
    access(0, 1'b0, 8'h05, 16'h0000, 3, 1'b0);
    check("rd_05", 32'(rdata_v[0]), 32'hBEEF);
    access(0, 1'b1, 8'h05, 16'h0000, 3, 1'b0);
    check("hold_after_wr", 32'(rdata_v[0]), 32'hBEEF);
    repeat (3) @(negedge clk);
    check("hold_idle", 32'(rdata_v[0]), 32'hBEEF);
    access(0, 1'b0, 8'h05, 16'h0000, 3, 1'b0);
    check("rd_05_new", 32'(rdata_v[0]), 32'h0000);

    // Reset in the middle of a three-wait-state write.
    access(3, 1'b1, 8'h30, 16'h0001, 5, 1'b0);
    access(3, 1'b0, 8'h30, 16'h0000, 5, 1'b0);
    check("rd_30_pre", 32'(rdata_v[3]), 32'h0001);
    @(negedge clk);
    req_v[3] = 1'b1; we = 1'b1; addr = 8'h30; wdata = 16'h7777;
    @(negedge clk);
    req_v[3] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy_v[3]), 32'd0);
    check("abort_rdata", 32'(rdata_v[3]), 32'h0);
    check("abort_done", 32'(done_v[3]), 32'd0);
    ndone = 0;
    repeat (8) begin
      if (done_v[3]) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    access(3, 1'b0, 8'h30, 16'h0000, 5, 1'b0);
    check("rd_30_post", 32'(rdata_v[3]), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Multi-cycle data-memory controller. It sits directly upstream of the data-bus mux and produces the 16-bit memory read word that the mux selects with its memory-output enable.
- The micro-sequencer issues a one-cycle request. Address comes from the address register; write data comes from the data-bus output.
- The controller holds the access for a configurable number of wait states, then pulses completion.
- The read word is held stable for the bus until the next read completes.

Parameters:
- ADDR_W, 8: address width in bits.
- DEPTH, 256: number of 16-bit words implemented; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 1: extra access cycles beyond the minimum; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  word address; sampled with req.
- wdata  input  16  write data from the data-bus output; sampled with req.
- busy  output  1  high while an access is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, for an out-of-range address.
- rdata  output  16  read word, the memory-output source for the data-bus mux.

Behaviour:
- Interface rule: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=16'h0000, wait counter=0. Memory contents are not cleared.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If req=1 at a rising edge: capture we, addr and wdata into internal registers; load the counter with WAIT_STATES; go to ACCESS.
  - If req=0: stay in IDLE.
- ACCESS:
  - busy=1.
  - If counter != 0: decrement and stay.
  - If counter == 0: perform the operation at this edge and go to DONE.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- Operation at the commit edge:
  - Write with in-range captured address: mem[addr] <= wdata.
  - Read with in-range captured address: rdata <= mem[addr].
  - Out-of-range address (addr >= DEPTH): no memory change; a read loads rdata <= 16'h0000; err=1 in DONE.
- DONE: busy=1, done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency: with req high in cycle 0, ACCESS covers cycles 1..WAIT_STATES+1, done=1 in cycle WAIT_STATES+2, and the next req is accepted in cycle WAIT_STATES+3 or later.
- Requests in ACCESS or DONE:
  - req is ignored; it is not queued.
  - Changes on we/addr/wdata after capture have no effect.
- rdata:
  - Changes only at a read commit edge or at reset.
  - Writes never change rdata, even to the same address.
- Read-after-write to the same address in consecutive transactions returns the newly written value.
- Reset has priority in every state. Reset asserted at the commit edge aborts the access: no memory write, rdata goes to 0, no done pulse.
- busy is a registered output derived from state. done and err are registered.

Test Plan:
- Write, then read (WAIT_STATES=1): write 16'hA5C3 to addr 8'h10, then read 8'h10. Required: done at cycle 3 after each req, busy high for cycles 1-3, rdata=16'hA5C3 after the read, err=0 throughout.
- Wait-state sweep: WAIT_STATES=0 and WAIT_STATES=5, read a pre-written address. Required: done at cycle 2 and cycle 7 respectively; done is exactly one cycle wide.
- Request while busy: pulse req (write, addr 8'h20, 16'h1111) in cycle 0, then req (write, 8'h21, 16'h2222) in cycle 1. Required: only mem[8'h20]=16'h1111 is written; mem[8'h21] is unchanged; exactly one done.
- Out of range (DEPTH=200): read addr 8'hC8. Required: rdata=16'h0000 and err=1 together with done. Write to 8'hFF: no memory location changes and err=1.
- rdata hold: read 8'h05 (value 16'hBEEF), then write 16'h0000 to 8'h05. Required: rdata stays 16'hBEEF until the next read commit.
- Reset mid-access (WAIT_STATES=3): start a write of 16'h7777 to 8'h30 with old value 16'h0001; assert rst in cycle 2. Required: state=IDLE, busy=0, rdata=0, no done. A subsequent read of 8'h30 returns 16'h0001.
